// File: rtl/vjith_pkg.sv
// rtl/vjith_pkg.sv - shared types and defaults for the instruction fetch buffer
//
// Purpose: fetch FSM state enum plus default queue depth and reset PC.
// Ports:   none (package).
package vjith_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // free to issue a request
    WAIT  = 2'd1,  // one request outstanding, response will be kept
    DRAIN = 2'd2   // one request outstanding, response will be dropped
  } fetch_state_e;

  localparam int unsigned VJITH_DEPTH    = 4;
  localparam logic [31:0] VJITH_RESET_PC = 32'd0;

endpackage

// File: rtl/vjith_ifq.sv
// rtl/vjith_ifq.sv - DEPTH x W prefetch FIFO with flush, push, pop and count
//
// Purpose: registered queue holding {instruction, next word address} pairs.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            clear occupancy and pointers (wins over push/pop)
//   push, wdata      write one entry
//   pop              drop the head entry
//   rdata            head entry
//   count            occupancy 0..DEPTH
//   full, empty      occupancy flags
module vjith_ifq #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vjith_ifetch_buf.sv
// rtl/vjith_ifetch_buf.sv - word-addressed instruction fetch with prefetch queue
//
// Purpose: issues one-at-a-time fetches from pc, queues returned words with
// their next address, serves them to decode, and flushes on branch redirect.
// Optional macro IFETCH_BYPASS_EN: an empty queue forwards the arriving word
// to decode combinationally in the response cycle.
// Ports:
//   clk, RN                          clock, asynchronous active-low reset
//   imem_req/addr/gnt                fetch request handshake (addr = pc)
//   imem_rvalid/rdata                fetch response
//   br_en, br_target                 redirect from execute
//   id_valid/ready/ir/npc            decode handshake and head of queue
//   pc                               next fetch word address
//   q_cnt                            queue occupancy
module vjith_ifetch_buf
  import vjith_pkg::*;
#(
  parameter int          DEPTH    = VJITH_DEPTH,
  parameter logic [31:0] RESET_PC = VJITH_RESET_PC
) (
  input  logic                    clk,
  input  logic                    RN,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    br_en,
  input  logic [31:0]             br_target,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [31:0]             id_ir,
  output logic [31:0]             id_npc,
  output logic [31:0]             pc,
  output logic [$clog2(DEPTH):0]  q_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  lat_q, lat_d;

  logic         q_push, q_pop, q_full, q_empty;
  logic [63:0]  q_head;
  logic         rsp_take;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = RN && (state_q == RUN) && !q_full && !br_en;
  // Only a response to a request we still want is ever written.
  assign rsp_take  = (state_q == WAIT) && imem_rvalid && !br_en;

`ifdef IFETCH_BYPASS_EN
  logic byp;
  assign byp      = rsp_take && q_empty;
  assign id_valid = RN && !br_en && (!q_empty || byp);
  assign id_ir    = byp ? imem_rdata : q_head[63:32];
  assign id_npc   = byp ? (lat_q + 32'd1) : q_head[31:0];
  assign q_push   = rsp_take && !(byp && id_ready);
  assign q_pop    = id_valid && id_ready && !byp;
`else
  assign id_valid = RN && !br_en && !q_empty;
  assign id_ir    = q_head[63:32];
  assign id_npc   = q_head[31:0];
  assign q_push   = rsp_take;
  assign q_pop    = id_valid && id_ready;
`endif

  vjith_ifq #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_ifq (
    .clk   (clk),
    .rst_n (RN),
    .flush (br_en),
    .push  (q_push),
    .wdata ({imem_rdata, lat_q + 32'd1}),
    .pop   (q_pop),
    .rdata (q_head),
    .count (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      lat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lat_d   = lat_q;
    case (state_q)
      RUN: begin
        if (imem_req && imem_gnt) begin
          pc_d    = pc_q + 32'd1;
          lat_d   = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response always ends WAIT; a redirect without one leaves a
        // response in flight that must be dropped later.
        if (imem_rvalid)  state_d = RUN;
        else if (br_en)   state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (br_en) pc_d = br_target;
  end

endmodule

// File: doc/vjith_ifetch_buf.md
VJITH_IFETCH_BUF -- requirements
Module: vjith_ifetch_buf

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DEPTH, 4, prefetch queue entries (power of 2, >=2)
  RESET_PC, 32'd0, first word address fetched after reset
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  RN  in  1  reset, asynchronous, active-low
  imem_req  out  1  fetch request valid
  imem_addr  out  32  word address of request (= pc)
  imem_gnt  in  1  request accepted this cycle
  imem_rvalid  in  1  response word valid
  imem_rdata  in  32  instruction word
  br_en  in  1  redirect strobe from execute
  br_target  in  32  redirect word address
  id_valid  out  1  instruction available to decode
  id_ready  in  1  decode accepts this cycle
  id_ir  out  32  instruction to decode
  id_npc  out  32  word address of that instruction + 1
  pc  out  32  next fetch word address
  q_cnt  out  $clog2(DEPTH)+1  queue occupancy

Function
REQ-003 Addressing SHALL be word-based: sequential pc advances by 32'd1, wrapping modulo 2^32.
REQ-004 FSM states SHALL be RUN, WAIT, DRAIN; at most one request outstanding.
REQ-005 imem_req SHALL be 1 iff state==RUN && (q_cnt < DEPTH) && !br_en.
REQ-006 imem_req && imem_gnt in RUN: pc <= pc+1, request address latched, state -> WAIT.
REQ-007 imem_rvalid in WAIT with no br_en: push {imem_rdata, latched_addr+1}, state -> RUN; no new request issued in that same cycle.
REQ-008 imem_rvalid in RUN or DRAIN-exit cycles outside WAIT SHALL be ignored.
REQ-009 id_valid SHALL be (q_cnt != 0) && !br_en; id_ir/id_npc SHALL show the queue head; a pop occurs on id_valid && id_ready.
REQ-010 Push and pop in the same cycle: q_cnt unchanged, head advances; read/write pointers wrap modulo DEPTH.
REQ-011 Queue full (q_cnt==DEPTH): no request issued; contents held until popped.
REQ-012 br_en at a clock edge SHALL flush the queue (q_cnt<=0, pointers<=0) and set pc<=br_target, overriding any push, pop, or increment.
REQ-013 br_en in WAIT without imem_rvalid: state -> DRAIN; br_en in WAIT with imem_rvalid: response discarded, state -> RUN.
REQ-014 In DRAIN, the first imem_rvalid SHALL be discarded and state -> RUN; a further br_en in DRAIN updates pc and stays in DRAIN.
REQ-015 Latency SHALL be 1 cycle from imem_rvalid to id_valid (registered queue), unless IFETCH_BYPASS_EN is defined.

Reset
REQ-016 RN low SHALL asynchronously force pc=RESET_PC, state=RUN, q_cnt=0, pointers=0, and latched address=0.
REQ-017 While RN is low, imem_req=0 and id_valid=0; queue storage need not be cleared.
REQ-018 An outstanding request killed by reset mid-operation SHALL have its late response ignored (REQ-008).

Configuration
REQ-019 Macro IFETCH_BYPASS_EN, when defined: if q_cnt==0 in WAIT with imem_rvalid and !br_en, id_valid=1 combinationally with id_ir=imem_rdata; the word is not pushed if id_ready=1 that cycle.
REQ-020 Macro IFETCH_BYPASS_EN, when undefined: no combinational path from imem_rdata to id_ir; REQ-015 latency applies.

Structure
REQ-021 Shared package vjith_pkg SHALL hold the fetch state enum (RUN, WAIT, DRAIN), the default DEPTH, and RESET_PC constants.
REQ-022 The queue SHALL be a sub-module vjith_ifq (DEPTH x 64-bit FIFO with flush, push, pop, count).

Verification
REQ-023 Reset release, imem_gnt=1, rvalid one cycle after gnt, id_ready=1 -> imem_addr 0,1,2..., id_ir matches memory, id_npc 1,2,3....
REQ-024 id_ready=0, DEPTH=4 -> exactly 4 words queued, q_cnt=4, imem_req=0; then id_ready=1 -> fetching resumes with address 4.
REQ-025 br_en with br_target=25 while in WAIT, response 2 cycles later -> stale word dropped, next imem_addr=25, next id_npc=26.
REQ-026 br_en coincident with imem_rvalid and id_ready -> q_cnt=0, id_valid=0 that cycle, pc=target.
REQ-027 RN pulsed low while in WAIT, imem_rvalid arrives after release -> ignored, first fetch at RESET_PC.
REQ-028 With IFETCH_BYPASS_EN defined, empty queue, rvalid with rdata=32'h02208300 -> id_valid=1 and id_ir=32'h02208300 in the same cycle, q_cnt remains 0.
